// File: rtl/hazard_pkg.sv
// Shared constants and helpers for the hazard scoreboard.
package hazard_pkg;

    // Forwarding select encodings: how many stages ahead of EX the value sits.
    localparam int SEL_RF    = 0;
    localparam int SEL_EXMEM = 1;
    localparam int SEL_MEMWB = 2;
    localparam int SEL_WB    = 3;

    // Producer latency is forced into 1..depth so that every entry retires.
    function automatic int unsigned clamp_lat(input int unsigned lat, input int unsigned depth);
        if (lat == 0)
            return 1;
        if (lat > depth)
            return depth;
        return lat;
    endfunction

endpackage

// File: rtl/sb_entry.sv
// One scoreboard entry: busy/age/latency of the newest in-flight producer of a register.
module sb_entry #(
    parameter int DEPTH  = 3,
    parameter int LW     = 2,
    parameter int FWD_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set,
    input  logic [LW-1:0] set_lat,
    output logic          ready,
    output logic [LW-1:0] sel
);
    import hazard_pkg::*;

    localparam logic [LW-1:0] AGE_LAST = LW'(DEPTH);

    logic          busy;
    logic [LW-1:0] age;
    logic [LW-1:0] lat;

    // A new producer overrides ageing; otherwise the entry walks toward WB and retires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            age  <= '0;
            lat  <= '0;
        end else if (set) begin
            busy <= 1'b1;
            age  <= LW'(1);
            lat  <= set_lat;
        end else if (busy) begin
            if (age == AGE_LAST) begin
                busy <= 1'b0;
                age  <= '0;
                lat  <= '0;
            end else begin
                age <= age + LW'(1);
            end
        end
    end

    // Ready means a consumer can take the value now, from the returned stage.
    always_comb begin
        ready = 1'b1;
        sel   = LW'(SEL_RF);
        if (busy) begin
            if (FWD_EN != 0) begin
                ready = (age >= lat);
                sel   = ready ? age : LW'(SEL_RF);
            end else begin
                ready = (age == AGE_LAST);
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage stall and operand-forwarding decision backed by a per-register scoreboard.
module hazard_scoreboard #(
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter int DEPTH  = 3,
    parameter int LW     = $clog2(DEPTH + 1),
    parameter int FWD_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          id_valid,
    input  logic [AW-1:0] id_rs,
    input  logic [AW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic          id_wr_en,
    input  logic [AW-1:0] id_rd,
    input  logic [LW-1:0] id_lat,
    input  logic          flush,
    output logic          stall,
    output logic          issue,
    output logic [LW-1:0] fwd_rs_sel,
    output logic [LW-1:0] fwd_rt_sel
);
    import hazard_pkg::*;

    logic          ent_rdy [NREG];
    logic [LW-1:0] ent_sel [NREG];
    logic          wr;
    logic [LW-1:0] lat_c;
    logic          chk_rs;
    logic          chk_rt;
    logic          hz_rs;
    logic          hz_rt;

    assign lat_c = LW'(clamp_lat(int'(id_lat), DEPTH));
    assign wr    = issue & id_wr_en & (id_rd != '0);

    // Register 0 is hard-wired and never tracked.
    assign ent_rdy[0] = 1'b1;
    assign ent_sel[0] = LW'(SEL_RF);

    genvar gi;
    generate
        for (gi = 1; gi < NREG; gi++) begin : g_ent
            sb_entry #(
                .DEPTH  (DEPTH),
                .LW     (LW),
                .FWD_EN (FWD_EN)
            ) u_ent (
                .clk     (clk),
                .rst     (rst),
                .set     (wr && (id_rd == AW'(gi))),
                .set_lat (lat_c),
                .ready   (ent_rdy[gi]),
                .sel     (ent_sel[gi])
            );
        end
    endgenerate

    // Read-out muxes and stall/issue combine; checks use pre-update state.
    always_comb begin
        chk_rs     = id_use_rs && (id_rs != '0);
        chk_rt     = id_use_rt && (id_rt != '0);
        hz_rs      = chk_rs && !ent_rdy[id_rs];
        hz_rt      = chk_rt && !ent_rdy[id_rt];
        fwd_rs_sel = chk_rs ? ent_sel[id_rs] : LW'(SEL_RF);
        fwd_rt_sel = chk_rt ? ent_sel[id_rt] : LW'(SEL_RF);
        stall      = id_valid && !flush && (hz_rs || hz_rt);
        issue      = id_valid && !flush && !stall;
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic       urs;
        logic [4:0] rt;
        logic       urt;
        logic       we;
        logic [4:0] rd;
        logic [1:0] lat;
        logic       fl;
        logic       st;
        logic       is;
        logic [1:0] ers;
        logic [1:0] ert;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
    logic       id_use_rs = 1'b0, id_use_rt = 1'b0, id_wr_en = 1'b0, flush = 1'b0;
    logic [1:0] id_lat = '0;
    logic       stall0, issue0, stall1, issue1;
    logic [1:0] rs0, rt0, rs1, rt1;

    int   vecs = 0;
    int   miss = 0;
    vec_t exp_q[$];

    always #5 clk = ~clk;

    hazard_scoreboard #(.FWD_EN(1)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
        .id_lat(id_lat), .flush(flush), .stall(stall0), .issue(issue0),
        .fwd_rs_sel(rs0), .fwd_rt_sel(rt0));

    hazard_scoreboard #(.FWD_EN(0)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en), .id_rd(id_rd),
        .id_lat(id_lat), .flush(flush), .stall(stall1), .issue(issue1),
        .fwd_rs_sel(rs1), .fwd_rt_sel(rt1));

    function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic urs,
                                input logic [4:0] rt, input logic urt, input logic we,
                                input logic [4:0] rd, input logic [1:0] lat, input logic fl,
                                input logic st, input logic is, input logic [1:0] ers,
                                input logic [1:0] ert);
        vec_t t;
        t = '{v:v, rs:rs, urs:urs, rt:rt, urt:urt, we:we, rd:rd, lat:lat, fl:fl,
              st:st, is:is, ers:ers, ert:ert};
        return t;
    endfunction

    // Apply one ID-stage vector just after a rising edge, queue its expectation, sample at falling edge.
    task automatic drive(input vec_t t);
        @(posedge clk); #1;
        id_valid = t.v; id_rs = t.rs; id_use_rs = t.urs; id_rt = t.rt; id_use_rt = t.urt;
        id_wr_en = t.we; id_rd = t.rd; id_lat = t.lat; flush = t.fl;
        exp_q.push_back(t);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            id_valid = 1'b0; id_use_rs = 1'b0; id_use_rt = 1'b0; id_wr_en = 1'b0; flush = 1'b0;
        end
    endtask

    task automatic test_reset();
        vec_t s[$];
        vec_t e;
        logic [1:0] grs, grt;
        #2;
        vecs++;
        if ({stall0, issue0, rs0, rt0} !== 6'b0) begin
            miss++; $display("FAIL reset_idle: got %b want 000000", {stall0, issue0, rs0, rt0});
        end
        id_valid = 1'b1; #1;
        vecs++;
        if ({stall0, issue0, rs0, rt0} !== 6'b010000) begin
            miss++; $display("FAIL reset_valid: got %b want 010000", {stall0, issue0, rs0, rt0});
        end
        id_valid = 1'b0; rst = 1'b0;
        s.push_back(mk(1, 0, 0, 0, 0, 1, 5, 2, 0, 0, 1, 0, 0));
        s.push_back(mk(1, 5, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
        foreach (s[i]) begin
            drive(s[i]);
            e = exp_q.pop_front();
            grs = e.is ? rs0 : e.ers; grt = e.is ? rt0 : e.ert;
            vecs++;
            if ({stall0, issue0, grs, grt} !== {e.st, e.is, e.ers, e.ert}) begin
                miss++; $display("FAIL reset_pre[%0d]: got st=%b is=%b rs=%0d rt=%0d want st=%b is=%b rs=%0d rt=%0d",
                                 i, stall0, issue0, grs, grt, e.st, e.is, e.ers, e.ert);
            end
        end
        rst = 1'b1; #1;
        vecs++;
        if ({stall0, issue0, rs0, rt0} !== 6'b010000) begin
            miss++; $display("FAIL reset_mid_stall: got %b want 010000", {stall0, issue0, rs0, rt0});
        end
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        vecs++;
        if ({stall0, issue0, rs0, rt0} !== 6'b010000) begin
            miss++; $display("FAIL reset_after: got %b want 010000", {stall0, issue0, rs0, rt0});
        end
        idle(4);
    endtask

    task automatic test_alu_fwd();
        vec_t s[$];
        vec_t e;
        logic [1:0] grs, grt;
        s.push_back(mk(1, 1, 1, 2, 1, 1, 3, 1, 0, 0, 1, 0, 0));
        s.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        s.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0));
        s.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0));
        s.push_back(mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 0, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 1, 0, 0));
        s.push_back(mk(1, 1, 1, 2, 1, 0, 0, 0, 0, 0, 1, 2, 1));
        foreach (s[i]) begin
            drive(s[i]);
            e = exp_q.pop_front();
            grs = e.is ? rs0 : e.ers; grt = e.is ? rt0 : e.ert;
            vecs++;
            if ({stall0, issue0, grs, grt} !== {e.st, e.is, e.ers, e.ert}) begin
                miss++; $display("FAIL alu_fwd[%0d]: got st=%b is=%b rs=%0d rt=%0d want st=%b is=%b rs=%0d rt=%0d",
                                 i, stall0, issue0, grs, grt, e.st, e.is, e.ers, e.ert);
            end
        end
        idle(4);
    endtask

    task automatic test_load_use();
        vec_t s[$];
        vec_t e;
        logic [1:0] grs, grt;
        s.push_back(mk(1, 0, 0, 0, 0, 1, 8, 2, 0, 0, 1, 0, 0));
        s.push_back(mk(1, 7, 1, 8, 1, 0, 0, 0, 0, 1, 0, 0, 0));
        s.push_back(mk(1, 7, 1, 8, 1, 0, 0, 0, 0, 0, 1, 0, 2));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 13, 3, 0, 0, 1, 0, 0));
        s.push_back(mk(1, 13, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        s.push_back(mk(1, 13, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        s.push_back(mk(1, 13, 1, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 11, 0, 0, 0, 1, 0, 0));
        s.push_back(mk(1, 11, 1, 11, 1, 0, 0, 0, 0, 0, 1, 1, 1));
        foreach (s[i]) begin
            drive(s[i]);
            e = exp_q.pop_front();
            grs = e.is ? rs0 : e.ers; grt = e.is ? rt0 : e.ert;
            vecs++;
            if ({stall0, issue0, grs, grt} !== {e.st, e.is, e.ers, e.ert}) begin
                miss++; $display("FAIL load_use[%0d]: got st=%b is=%b rs=%0d rt=%0d want st=%b is=%b rs=%0d rt=%0d",
                                 i, stall0, issue0, grs, grt, e.st, e.is, e.ers, e.ert);
            end
        end
        idle(4);
    endtask

    task automatic test_waw_flush_r0();
        vec_t s[$];
        vec_t e;
        logic [1:0] grs, grt;
        s.push_back(mk(1, 0, 0, 0, 0, 1, 4, 2, 0, 0, 1, 0, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 4, 1, 0, 0, 1, 0, 0));
        s.push_back(mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 9, 2, 0, 0, 1, 0, 0));
        s.push_back(mk(1, 9, 1, 0, 0, 1, 10, 1, 1, 0, 0, 0, 0));
        s.push_back(mk(1, 9, 1, 10, 1, 0, 0, 0, 0, 0, 1, 2, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0));
        s.push_back(mk(1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 12, 2, 0, 0, 1, 0, 0));
        s.push_back(mk(1, 12, 1, 0, 0, 1, 12, 1, 0, 1, 0, 0, 0));
        foreach (s[i]) begin
            drive(s[i]);
            e = exp_q.pop_front();
            grs = e.is ? rs0 : e.ers; grt = e.is ? rt0 : e.ert;
            vecs++;
            if ({stall0, issue0, grs, grt} !== {e.st, e.is, e.ers, e.ert}) begin
                miss++; $display("FAIL waw_flush_r0[%0d]: got st=%b is=%b rs=%0d rt=%0d want st=%b is=%b rs=%0d rt=%0d",
                                 i, stall0, issue0, grs, grt, e.st, e.is, e.ers, e.ert);
            end
        end
        idle(4);
    endtask

    task automatic test_fwd_off();
        vec_t s[$];
        vec_t e;
        logic [1:0] grs, grt;
        s.push_back(mk(1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 1, 0, 0));
        s.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        s.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        s.push_back(mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        foreach (s[i]) begin
            drive(s[i]);
            e = exp_q.pop_front();
            grs = e.is ? rs1 : e.ers; grt = e.is ? rt1 : e.ert;
            vecs++;
            if ({stall1, issue1, grs, grt} !== {e.st, e.is, e.ers, e.ert}) begin
                miss++; $display("FAIL fwd_off[%0d]: got st=%b is=%b rs=%0d rt=%0d want st=%b is=%b rs=%0d rt=%0d",
                                 i, stall1, issue1, grs, grt, e.st, e.is, e.ers, e.ert);
            end
        end
        idle(4);
    endtask

    initial begin
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_waw_flush_r0();
        test_fwd_off();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
